// File: rtl/execute_hazard_controller_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package execute_hazard_controller_pkg;
   localparam int ADDR_WIDTH = 5;
   typedef logic [31:0] WORD;
   typedef logic        mem_read_signal;

   localparam int MULT_CYCLES_DEFAULT  = 3;
   localparam int FLUSH_CYCLES_DEFAULT = 2;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      MULTI = 2'd1,
      FLUSH = 2'd2
   } hazard_state;
endpackage

// File: rtl/execute_hazard_controller_cycle_counter.sv
// Loadable 4-bit down-counter shared by the MULTI and FLUSH sequences.
module hazard_cycle_counter (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_dec,
   output logic       o_zero
);
   logic [3:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (reset_i)                   r_cnt <= 4'd0;
      else if (i_load)               r_cnt <= i_load_val;
      else if (i_dec && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
   end

   assign o_zero = (r_cnt == 4'd0);
endmodule

// File: rtl/execute_hazard_controller.sv
// Stall/flush/bubble sequencing for load-use, multi-cycle ops and taken branches.
module execute_hazard_controller
   import execute_hazard_controller_pkg::*;
#(
   parameter int MULT_CYCLES  = MULT_CYCLES_DEFAULT,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  is_valid_DECODE_i,
   input  logic                  uses_reg_1_DECODE_i,
   input  logic                  uses_reg_2_DECODE_i,
   input  logic [ADDR_WIDTH-1:0] reg_1_source_addr_DECODE_i,
   input  logic [ADDR_WIDTH-1:0] reg_2_source_addr_DECODE_i,
   input  logic                  is_valid_EXE_i,
   input  mem_read_signal        mem_read_en_EXE_i,
   input  logic [ADDR_WIDTH-1:0] reg_dest_EXE_i,
   input  logic                  multi_cycle_EXE_i,
   input  logic                  branch_taken_EXE_i,
   output logic                  stall_fetch_o,
   output logic                  stall_decode_o,
   output logic                  stall_exe_o,
   output logic                  flush_decode_o,
   output logic                  exe_bubble_o,
   output logic                  mem_bubble_o,
   output WORD                   stall_cycles_o
);
   // Counter preload values: entry cycle is already spent, hence the -2.
   localparam logic [3:0] LP_MULT_LOAD  = (MULT_CYCLES  > 1) ? 4'(MULT_CYCLES  - 2) : 4'd0;
   localparam logic [3:0] LP_FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
   localparam logic       LP_MULT_EN    = (MULT_CYCLES  > 1);
   localparam logic       LP_FLUSH_EN   = (FLUSH_CYCLES > 1);

   hazard_state r_state, w_next_state;
   logic        w_cnt_load, w_cnt_dec, w_cnt_zero;
   logic [3:0]  w_cnt_load_val;
   logic        w_load_use, w_branch, w_multi;
   WORD         r_stall_cycles;

   assign w_load_use = is_valid_EXE_i & mem_read_en_EXE_i & is_valid_DECODE_i &
                       ((uses_reg_1_DECODE_i & (reg_1_source_addr_DECODE_i == reg_dest_EXE_i)) |
                        (uses_reg_2_DECODE_i & (reg_2_source_addr_DECODE_i == reg_dest_EXE_i)));
   assign w_branch   = is_valid_EXE_i & branch_taken_EXE_i;
   assign w_multi    = is_valid_EXE_i & multi_cycle_EXE_i & LP_MULT_EN;

   hazard_cycle_counter u_cnt (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= RUN;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state   = r_state;
      w_cnt_load     = 1'b0;
      w_cnt_load_val = 4'd0;
      w_cnt_dec      = 1'b0;
      case (r_state)
         RUN: begin
            if (w_branch) begin
               if (LP_FLUSH_EN) begin
                  w_next_state   = FLUSH;
                  w_cnt_load     = 1'b1;
                  w_cnt_load_val = LP_FLUSH_LOAD;
               end
            end else if (w_multi) begin
               w_next_state   = MULTI;
               w_cnt_load     = 1'b1;
               w_cnt_load_val = LP_MULT_LOAD;
            end
         end
         MULTI: begin
            if (w_cnt_zero) w_next_state = RUN;
            else            w_cnt_dec    = 1'b1;
         end
         FLUSH: begin
            if (w_cnt_zero) w_next_state = RUN;
            else            w_cnt_dec    = 1'b1;
         end
         default: w_next_state = RUN;
      endcase
   end

   always_comb begin
      stall_fetch_o  = 1'b0;
      stall_decode_o = 1'b0;
      stall_exe_o    = 1'b0;
      flush_decode_o = 1'b0;
      exe_bubble_o   = 1'b0;
      mem_bubble_o   = 1'b0;
      if (!reset_i) begin
         case (r_state)
            RUN: begin
               if (w_branch) begin
                  flush_decode_o = 1'b1;
                  exe_bubble_o   = 1'b1;
               end else if (w_multi) begin
                  stall_fetch_o  = 1'b1;
                  stall_decode_o = 1'b1;
                  stall_exe_o    = 1'b1;
                  mem_bubble_o   = 1'b1;
               end else if (w_load_use) begin
                  stall_fetch_o  = 1'b1;
                  stall_decode_o = 1'b1;
                  exe_bubble_o   = 1'b1;
               end
            end
            MULTI: begin
               if (!w_cnt_zero) begin
                  stall_fetch_o  = 1'b1;
                  stall_decode_o = 1'b1;
                  stall_exe_o    = 1'b1;
                  mem_bubble_o   = 1'b1;
               end
            end
            FLUSH:   flush_decode_o = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_stall_cycles <= '0;
      else if (stall_decode_o && (r_stall_cycles != 32'hFFFF_FFFF))
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign stall_cycles_o = r_stall_cycles;
endmodule

// File: tb/tb_execute_hazard_controller.sv
// Directed bench for execute_hazard_controller at MULT_CYCLES=3, FLUSH_CYCLES=2.
module tb_execute_hazard_controller;
   import execute_hazard_controller_pkg::*;

   logic                  clk_i = 1'b0;
   logic                  reset_i;
   logic                  is_valid_DECODE_i, uses_reg_1_DECODE_i, uses_reg_2_DECODE_i;
   logic [ADDR_WIDTH-1:0] reg_1_source_addr_DECODE_i, reg_2_source_addr_DECODE_i;
   logic                  is_valid_EXE_i;
   mem_read_signal        mem_read_en_EXE_i;
   logic [ADDR_WIDTH-1:0] reg_dest_EXE_i;
   logic                  multi_cycle_EXE_i, branch_taken_EXE_i;
   logic                  stall_fetch_o, stall_decode_o, stall_exe_o;
   logic                  flush_decode_o, exe_bubble_o, mem_bubble_o;
   WORD                   stall_cycles_o;

   int checks = 0;
   int errors = 0;

   // {stall_fetch, stall_decode, stall_exe, flush_decode, exe_bubble, mem_bubble}
   logic [5:0] ctl;
   assign ctl = {stall_fetch_o, stall_decode_o, stall_exe_o, flush_decode_o, exe_bubble_o, mem_bubble_o};

   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_LU    = 6'b110010;
   localparam logic [5:0] C_MULTI = 6'b111001;
   localparam logic [5:0] C_BR    = 6'b000110;
   localparam logic [5:0] C_FL    = 6'b000100;

   execute_hazard_controller #(.MULT_CYCLES(3), .FLUSH_CYCLES(2)) dut (
      .clk_i                      (clk_i),
      .reset_i                    (reset_i),
      .is_valid_DECODE_i          (is_valid_DECODE_i),
      .uses_reg_1_DECODE_i        (uses_reg_1_DECODE_i),
      .uses_reg_2_DECODE_i        (uses_reg_2_DECODE_i),
      .reg_1_source_addr_DECODE_i (reg_1_source_addr_DECODE_i),
      .reg_2_source_addr_DECODE_i (reg_2_source_addr_DECODE_i),
      .is_valid_EXE_i             (is_valid_EXE_i),
      .mem_read_en_EXE_i          (mem_read_en_EXE_i),
      .reg_dest_EXE_i             (reg_dest_EXE_i),
      .multi_cycle_EXE_i          (multi_cycle_EXE_i),
      .branch_taken_EXE_i         (branch_taken_EXE_i),
      .stall_fetch_o              (stall_fetch_o),
      .stall_decode_o             (stall_decode_o),
      .stall_exe_o                (stall_exe_o),
      .flush_decode_o             (flush_decode_o),
      .exe_bubble_o               (exe_bubble_o),
      .mem_bubble_o               (mem_bubble_o),
      .stall_cycles_o             (stall_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   // Inputs change on the falling edge; outputs sampled 1ns later, well away from posedge.
   task automatic next_cycle();
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      is_valid_DECODE_i = 0; uses_reg_1_DECODE_i = 0; uses_reg_2_DECODE_i = 0;
      reg_1_source_addr_DECODE_i = '0; reg_2_source_addr_DECODE_i = '0;
      is_valid_EXE_i = 0; mem_read_en_EXE_i = 0; reg_dest_EXE_i = '0;
      multi_cycle_EXE_i = 0; branch_taken_EXE_i = 0;
   endtask

   // EXE load to r3, decode reads r1 (src1) and r3 (src2).
   task automatic drive_load_use(input logic use2);
      idle_inputs();
      is_valid_EXE_i = 1; mem_read_en_EXE_i = 1; reg_dest_EXE_i = 5'd3;
      is_valid_DECODE_i = 1; uses_reg_1_DECODE_i = 1; reg_1_source_addr_DECODE_i = 5'd1;
      uses_reg_2_DECODE_i = use2; reg_2_source_addr_DECODE_i = 5'd3;
   endtask

   task automatic drive_multi();
      idle_inputs();
      is_valid_EXE_i = 1; multi_cycle_EXE_i = 1; reg_dest_EXE_i = 5'd7;
   endtask

   task automatic test_reset();
      reset_i = 1; drive_load_use(1'b1);
      #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_NONE); end
      next_cycle(); #1;
      checks++; if (stall_cycles_o !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", stall_cycles_o); end
      checks++; if (dut.r_state !== RUN) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.r_state, RUN); end
      reset_i = 0; idle_inputs();
      next_cycle();
   endtask

   task automatic test_load_use();
      drive_load_use(1'b1); #1;
      checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_ctl got %b want %b", ctl, C_LU); end
      next_cycle(); idle_inputs(); #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_clear got %b want %b", ctl, C_NONE); end
      checks++; if (stall_cycles_o !== 32'd1) begin errors++; $display("FAIL lu_count got %0d want 1", stall_cycles_o); end
      next_cycle();
   endtask

   task automatic test_unused_source();
      drive_load_use(1'b0); #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL unused_ctl got %b want %b", ctl, C_NONE); end
      next_cycle(); idle_inputs(); #1;
      checks++; if (stall_cycles_o !== 32'd1) begin errors++; $display("FAIL unused_count got %0d want 1", stall_cycles_o); end
      next_cycle();
   endtask

   task automatic test_multi();
      drive_multi(); #1;
      checks++; if (ctl !== C_MULTI) begin errors++; $display("FAIL multi_T got %b want %b", ctl, C_MULTI); end
      next_cycle(); #1;
      checks++; if (ctl !== C_MULTI) begin errors++; $display("FAIL multi_T1 got %b want %b", ctl, C_MULTI); end
      next_cycle(); #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL multi_T2 got %b want %b", ctl, C_NONE); end
      next_cycle(); idle_inputs(); #1;
      checks++; if (dut.r_state !== RUN) begin errors++; $display("FAIL multi_state got %0d want %0d", dut.r_state, RUN); end
      checks++; if (stall_cycles_o !== 32'd3) begin errors++; $display("FAIL multi_count got %0d want 3", stall_cycles_o); end
      next_cycle();
   endtask

   task automatic test_branch();
      drive_load_use(1'b1); branch_taken_EXE_i = 1; #1;
      checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_T got %b want %b", ctl, C_BR); end
      next_cycle(); #1;
      checks++; if (ctl !== C_FL) begin errors++; $display("FAIL br_T1 got %b want %b", ctl, C_FL); end
      next_cycle(); idle_inputs(); #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL br_T2 got %b want %b", ctl, C_NONE); end
      checks++; if (stall_cycles_o !== 32'd3) begin errors++; $display("FAIL br_count got %0d want 3", stall_cycles_o); end
      next_cycle();
   endtask

   // Multi-cycle op, then a load-use shows up during the release cycle: stalled only once back in RUN.
   task automatic test_back_to_back();
      drive_multi(); next_cycle(); next_cycle();
      drive_load_use(1'b1); #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL b2b_release got %b want %b", ctl, C_NONE); end
      next_cycle(); #1;
      checks++; if (ctl !== C_LU) begin errors++; $display("FAIL b2b_lu got %b want %b", ctl, C_LU); end
      next_cycle(); idle_inputs(); #1;
      checks++; if (stall_cycles_o !== 32'd6) begin errors++; $display("FAIL b2b_count got %0d want 6", stall_cycles_o); end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      drive_multi(); next_cycle();
      reset_i = 1; #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL rmid_ctl got %b want %b", ctl, C_NONE); end
      next_cycle(); reset_i = 0; idle_inputs(); #1;
      checks++; if (dut.r_state !== RUN) begin errors++; $display("FAIL rmid_state got %0d want %0d", dut.r_state, RUN); end
      checks++; if (dut.u_cnt.r_cnt !== 4'd0) begin errors++; $display("FAIL rmid_cnt got %0d want 0", dut.u_cnt.r_cnt); end
      checks++; if (stall_cycles_o !== 32'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", stall_cycles_o); end
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL rmid_after got %b want %b", ctl, C_NONE); end
      next_cycle();
   endtask

   task automatic test_saturation();
      force dut.r_stall_cycles = 32'hFFFF_FFFE;
      #1 release dut.r_stall_cycles;
      drive_load_use(1'b1); next_cycle(); #1;
      checks++; if (stall_cycles_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_1 got %h want ffffffff", stall_cycles_o); end
      next_cycle(); next_cycle(); idle_inputs(); #1;
      checks++; if (stall_cycles_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_3 got %h want ffffffff", stall_cycles_o); end
      next_cycle();
   endtask

   initial begin
      reset_i = 1; idle_inputs();
      next_cycle();
      test_reset();
      test_load_use();
      test_unused_source();
      test_multi();
      test_branch();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/execute_hazard_controller.md
# execute_hazard_controller

Pipeline hazard and sequencing controller for the execute stage. It watches the decode and execute stages and generates stall, flush and bubble controls for the fetch/decode register, the decode/execute register and the execution/memory register. It sequences three hazard types: load-use, multi-cycle execute operations and taken branches. It sits beside the execution block; its bubbles act by forcing `is_valid` low on the downstream pipeline register.

## Interface
Parameters:
- `MULT_CYCLES`, 3: cycles a multi-cycle op occupies EXE; legal range 1..15.
- `FLUSH_CYCLES`, 2: cycles of fetch/decode squash after a taken branch; legal range 1..15.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `is_valid_DECODE_i`  in  1  decode holds a valid instruction.
- `uses_reg_1_DECODE_i`, `uses_reg_2_DECODE_i`  in  1 each  decode instruction reads source 1 / source 2.
- `reg_1_source_addr_DECODE_i`, `reg_2_source_addr_DECODE_i`  in  ADDR_WIDTH each  decode source addresses.
- `is_valid_EXE_i`  in  1  EXE holds a valid instruction.
- `mem_read_en_EXE_i`  in  mem_read_signal  EXE instruction is a load.
- `reg_dest_EXE_i`  in  ADDR_WIDTH  EXE destination register.
- `multi_cycle_EXE_i`  in  1  EXE instruction is a multi-cycle ALU op.
- `branch_taken_EXE_i`  in  1  EXE resolved a taken branch.
- `stall_fetch_o`  out  1  hold the PC.
- `stall_decode_o`  out  1  hold the fetch/decode register.
- `stall_exe_o`  out  1  hold the decode/execute register.
- `flush_decode_o`  out  1  clear valid in the fetch/decode register.
- `exe_bubble_o`  out  1  load an invalid entry into the decode/execute register.
- `mem_bubble_o`  out  1  load an invalid entry into the execution/memory register.
- `stall_cycles_o`  out  32  saturating count of cycles with `stall_decode_o` high.

## Operation
- State machine states: RUN, MULTI, FLUSH. A 4-bit down-counter `cnt` is shared between MULTI and FLUSH.
- Control outputs are Mealy: they are a combinational function of the current state and inputs. `stall_cycles_o` is registered.
- `load_use` = `is_valid_EXE_i` & load & `is_valid_DECODE_i` & ((`uses_reg_1` & src1==`reg_dest_EXE_i`) | (`uses_reg_2` & src2==`reg_dest_EXE_i`)).
- In RUN, hazards are resolved in priority order:
  - **Branch taken** (with valid EXE): assert `flush_decode_o` and `exe_bubble_o`. If `FLUSH_CYCLES`>1, go to FLUSH with `cnt`=`FLUSH_CYCLES`-2.
  - **Multi-cycle op** (with valid EXE) and `MULT_CYCLES`>1: assert `stall_fetch_o`, `stall_decode_o`, `stall_exe_o` and `mem_bubble_o`. Go to MULTI with `cnt`=`MULT_CYCLES`-2.
  - **Load-use**: assert `stall_fetch_o`, `stall_decode_o` and `exe_bubble_o` for one cycle. Stay in RUN.
  - **Otherwise**: all controls low.
- MULTI:
  - If `cnt`!=0: assert the same four signals as MULTI entry and decrement `cnt`.
  - If `cnt`==0: all controls low; go to RUN. The op advances this cycle.
  - All decode/EXE inputs are ignored in MULTI.
- FLUSH:
  - Assert `flush_decode_o` only.
  - If `cnt`==0, go to RUN; otherwise decrement `cnt`.
  - Branch, load-use and multi-cycle inputs are ignored in FLUSH.
- Load-use is re-evaluated in the first RUN cycle after MULTI or FLUSH.
- A load and a multi-cycle op are never both flagged on one EXE instruction. If they are, the multi-cycle path wins.
- `stall_cycles_o` increments on every cycle with `stall_decode_o` high and holds at 0xFFFF_FFFF.

## Timing
- Reset:
  - While `reset_i` is high, all control outputs are forced to 0.
  - At the next edge: state=RUN, `cnt`=0, `stall_cycles_o`=0.
  - Reset mid-MULTI or mid-FLUSH abandons the sequence immediately.
- Latency of control outputs: 0 cycles from inputs (same cycle).
- Multi-cycle op detected at cycle T:
  - Occupies EXE during T..T+`MULT_CYCLES`-1.
  - Stalls are high during T..T+`MULT_CYCLES`-2.
  - `MULT_CYCLES`=1 produces no stall.
- Branch at cycle T: `flush_decode_o` is high during T..T+`FLUSH_CYCLES`-1; `exe_bubble_o` is high at T only.
- Load-use: exactly one stall cycle per hazard instance.

## Structure
- Shared package gets:
  - a `hazard_state` enum (RUN/MULTI/FLUSH);
  - `MULT_CYCLES_DEFAULT` and `FLUSH_CYCLES_DEFAULT` constants;
  - reuse of the existing `mem_read_signal`, `ADDR_WIDTH` and `WORD` definitions.
- One sub-module: `hazard_cycle_counter`. It is a 4-bit loadable down-counter with a `zero_o` flag, shared by MULTI and FLUSH.

## Test plan
- **Load-use:** EXE load, dest r3; decode reads r3 via src2. Expected: one cycle of stall_fetch/stall_decode/exe_bubble, then clear; `stall_cycles_o`=1.
- **Unused source:** same as load-use, but `uses_reg_2`=0. Expected: no stall.
- **Multi-cycle op:** `MULT_CYCLES`=3, op at T. Expected: stalls and `mem_bubble_o` high at T and T+1, low at T+2; state returns to RUN.
- **Branch flush:** `FLUSH_CYCLES`=2; branch plus a simultaneous load-use. Expected: `flush_decode_o` high at T and T+1, `exe_bubble_o` high at T only, no stall.
- **Reset mid-sequence:** reset asserted in the second MULTI cycle. Expected: outputs 0 that cycle; RUN, `cnt`=0 and count=0 after the edge.
- **Counter saturation:** preload the count to 0xFFFF_FFFE, then trigger 3 load-use stalls. Expected: count holds at 0xFFFF_FFFF.
